// File: rtl/sauria_job_sequencer_pkg.sv
// rtl/sauria_job_sequencer_pkg.sv - shared types and register map defaults for the SAURIA job sequencer
package sauria_job_sequencer_pkg;

  localparam int unsigned DEFAULT_NUM_REGS     = 8;
  localparam logic [31:0] DEFAULT_START_OFFSET = 32'h0000_0100;
  localparam logic [31:0] DEFAULT_CLR_OFFSET   = 32'h0000_0104;
  localparam logic [31:0] SAURIA_GO            = 32'h0000_0001;

  typedef enum logic [2:0] {
    SEQ_IDLE,
    SEQ_CFG,
    SEQ_START,
    SEQ_WAIT_DONE,
    SEQ_CLEAR
  } seq_state_e;

  typedef logic [DEFAULT_NUM_REGS-1:0][31:0] sauria_job_t;

endpackage

// File: rtl/sauria_job_sequencer_queue.sv
// rtl/sauria_job_sequencer_queue.sv - descriptor FIFO with same-cycle flush
module sauria_job_sequencer_queue #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             flush_i,
  input  logic             in_tvalid,
  output logic             in_tready,
  input  logic [WIDTH-1:0] in_tdata,
  output logic             out_tvalid,
  input  logic             out_tready,
  output logic [WIDTH-1:0] out_tdata
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam logic [PTR_W:0] FULL_CNT = (PTR_W+1)'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W:0]   count;
  logic             push;
  logic             pop;

  assign in_tready  = (count != FULL_CNT);
  assign out_tvalid = (count != '0);
  assign out_tdata  = mem[rd_ptr];
  assign push       = in_tvalid && in_tready;
  assign pop        = out_tvalid && out_tready;

  // Flush wins over any push or pop in the same cycle.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush_i) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      count <= count + (PTR_W+1)'(push) - (PTR_W+1)'(pop);
    end
  end

  always_ff @(posedge clk_i) begin
    if (push && !flush_i) mem[wr_ptr] <= in_tdata;
  end

endmodule

// File: rtl/sauria_job_sequencer.sv
// rtl/sauria_job_sequencer.sv - queues SAURIA job descriptors and drives config, start, done and clear
module sauria_job_sequencer
  import sauria_job_sequencer_pkg::*;
#(
  parameter int unsigned NUM_REGS     = DEFAULT_NUM_REGS,
  parameter int unsigned QUEUE_DEPTH  = 4,
  parameter logic [31:0] BASE_ADDR    = 32'h0000_0000,
  parameter logic [31:0] START_OFFSET = DEFAULT_START_OFFSET,
  parameter logic [31:0] CLR_OFFSET   = DEFAULT_CLR_OFFSET,
  parameter logic [31:0] TIMEOUT      = 32'd1_000_000
) (
  input  logic                    clk_i,
  input  logic                    rst_ni,
  input  logic                    job_valid_i,
  output logic                    job_ready_o,
  input  logic [NUM_REGS*32-1:0]  job_data_i,
  input  logic                    abort_i,
  input  logic                    err_clr_i,
  output logic                    cfg_req_o,
  output logic                    cfg_we_o,
  output logic [31:0]             cfg_addr_o,
  output logic [31:0]             cfg_wdata_o,
  input  logic                    cfg_gnt_i,
  input  logic                    cfg_rvalid_i,
  input  logic                    sauria_done_i,
  output logic                    busy_o,
  output logic                    irq_o,
  output logic                    err_o,
  output logic [15:0]             jobs_done_o
);

  localparam int unsigned      IDX_W    = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_REGS - 1);

  seq_state_e             state;
  logic [NUM_REGS*32-1:0] job_q;
  logic [IDX_W-1:0]       word_idx;
  logic                   rsp_pending;
  logic                   abort_pending;
  logic [31:0]            wdog;
  logic [15:0]            jobs_done_q;
  logic                   q_tvalid;
  logic [NUM_REGS*32-1:0] q_tdata;
  logic                   pop;
  logic                   rsp_done;
  logic                   drain_abort;

  assign pop         = (state == SEQ_IDLE) && q_tvalid && !abort_i;
  assign rsp_done    = rsp_pending && cfg_rvalid_i;
  assign drain_abort = abort_pending || abort_i;
  assign cfg_we_o    = cfg_req_o;
  assign busy_o      = (state != SEQ_IDLE);
  assign jobs_done_o = jobs_done_q;

  sauria_job_sequencer_queue #(
    .DEPTH (QUEUE_DEPTH),
    .WIDTH (NUM_REGS*32)
  ) u_queue (
    .clk_i      (clk_i),
    .rst_ni     (rst_ni),
    .flush_i    (abort_i),
    .in_tvalid  (job_valid_i),
    .in_tready  (job_ready_o),
    .in_tdata   (job_data_i),
    .out_tvalid (q_tvalid),
    .out_tready (pop),
    .out_tdata  (q_tdata)
  );

  // Every bus write is issued on a state change and retired by rvalid, so a new
  // request is only raised in the cycle that sees the previous response.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state         <= SEQ_IDLE;
      job_q         <= '0;
      word_idx      <= '0;
      rsp_pending   <= 1'b0;
      abort_pending <= 1'b0;
      wdog          <= '0;
      jobs_done_q   <= '0;
      cfg_req_o     <= 1'b0;
      cfg_addr_o    <= '0;
      cfg_wdata_o   <= '0;
      irq_o         <= 1'b0;
      err_o         <= 1'b0;
    end else begin
      irq_o <= 1'b0;
      if (cfg_req_o && cfg_gnt_i) begin
        cfg_req_o   <= 1'b0;
        rsp_pending <= 1'b1;
      end
      if (rsp_done) rsp_pending <= 1'b0;
      if (abort_i && (state inside {SEQ_CFG, SEQ_START, SEQ_CLEAR})) abort_pending <= 1'b1;
      if (err_clr_i) err_o <= 1'b0;

      case (state)
        SEQ_IDLE: begin
          if (pop) begin
            job_q       <= q_tdata;
            word_idx    <= '0;
            cfg_req_o   <= 1'b1;
            cfg_addr_o  <= BASE_ADDR;
            cfg_wdata_o <= q_tdata[31:0];
            state       <= SEQ_CFG;
          end
        end
        SEQ_CFG: begin
          if (rsp_done) begin
            if (drain_abort) begin
              abort_pending <= 1'b0;
              state         <= SEQ_IDLE;
            end else if (word_idx == LAST_IDX) begin
              cfg_req_o   <= 1'b1;
              cfg_addr_o  <= BASE_ADDR + START_OFFSET;
              cfg_wdata_o <= SAURIA_GO;
              state       <= SEQ_START;
            end else begin
              word_idx    <= word_idx + 1'b1;
              cfg_req_o   <= 1'b1;
              cfg_addr_o  <= BASE_ADDR + ((32'(word_idx) + 32'd1) << 2);
              cfg_wdata_o <= job_q[32*(int'(word_idx)+1) +: 32];
            end
          end
        end
        SEQ_START: begin
          if (rsp_done) begin
            abort_pending <= 1'b0;
            wdog          <= '0;
            state         <= drain_abort ? SEQ_IDLE : SEQ_WAIT_DONE;
          end
        end
        SEQ_WAIT_DONE: begin
          // Abort beats done, and done beats watchdog expiry.
          if (abort_i) begin
            state <= SEQ_IDLE;
          end else if (sauria_done_i) begin
            cfg_req_o   <= 1'b1;
            cfg_addr_o  <= BASE_ADDR + CLR_OFFSET;
            cfg_wdata_o <= SAURIA_GO;
            state       <= SEQ_CLEAR;
          end else if ((TIMEOUT != '0) && (wdog == TIMEOUT - 32'd1)) begin
            err_o <= 1'b1;
            irq_o <= 1'b1;
            state <= SEQ_IDLE;
          end else begin
            wdog <= wdog + 32'd1;
          end
        end
        SEQ_CLEAR: begin
          if (rsp_done) begin
            abort_pending <= 1'b0;
            if (!drain_abort) begin
              irq_o       <= 1'b1;
              jobs_done_q <= jobs_done_q + 16'd1;
            end
            state <= SEQ_IDLE;
          end
        end
        default: state <= SEQ_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_sauria_job_sequencer.sv
// tb/tb_sauria_job_sequencer.sv - directed self-checking bench for the SAURIA job sequencer
module tb_sauria_job_sequencer;
  import sauria_job_sequencer_pkg::*;

  localparam logic [31:0] START_A = 32'h0000_0100;
  localparam logic [31:0] CLR_A   = 32'h0000_0104;

  typedef struct {
    int gnt_hi;
    int rsp_lo;
    int rsp_hi;
    int njobs;
    int exp_irq;
    int exp_done;
  } vec_t;

  logic        clk_i = 1'b0;
  logic        rst_ni = 1'b0;
  logic        job_valid_i = 1'b0;
  logic        job_ready_o;
  sauria_job_t job_data_i = '0;
  logic        abort_i = 1'b0;
  logic        err_clr_i = 1'b0;
  logic        cfg_req_o;
  logic        cfg_we_o;
  logic [31:0] cfg_addr_o;
  logic [31:0] cfg_wdata_o;
  logic        cfg_gnt_i = 1'b0;
  logic        cfg_rvalid_i = 1'b0;
  logic        sauria_done_i = 1'b0;
  logic        busy_o;
  logic        irq_o;
  logic        err_o;
  logic [15:0] jobs_done_o;

  int n_chk = 0;
  int n_pass = 0;
  int cyc = 0;
  int gnt_hi = 0;
  int rsp_lo = 1;
  int rsp_hi = 1;
  bit done_en = 1'b1;
  int gnt_cnt = 0;
  int rsp_cnt = 0;
  int done_timer = 0;
  logic [31:0] pend_addr = '0;
  logic [31:0] prev_addr = '0;
  logic [31:0] prev_wdata = '0;
  bit prev_wait = 1'b0;
  bit prev_irq = 1'b0;
  int proto_err = 0;
  int irq_cnt = 0;
  int last_irq_cyc = 0;
  int start_rv_cyc = 0;
  logic [63:0] log_mem [1024];
  int log_n = 0;
  logic [63:0] exp_mem [1024];
  int exp_n = 0;
  int lb = 0;
  int eb = 0;

  sauria_job_sequencer #(
    .NUM_REGS     (8),
    .QUEUE_DEPTH  (4),
    .BASE_ADDR    (32'h0000_0000),
    .START_OFFSET (START_A),
    .CLR_OFFSET   (CLR_A),
    .TIMEOUT      (32'd100)
  ) dut (
    .clk_i         (clk_i),
    .rst_ni        (rst_ni),
    .job_valid_i   (job_valid_i),
    .job_ready_o   (job_ready_o),
    .job_data_i    (job_data_i),
    .abort_i       (abort_i),
    .err_clr_i     (err_clr_i),
    .cfg_req_o     (cfg_req_o),
    .cfg_we_o      (cfg_we_o),
    .cfg_addr_o    (cfg_addr_o),
    .cfg_wdata_o   (cfg_wdata_o),
    .cfg_gnt_i     (cfg_gnt_i),
    .cfg_rvalid_i  (cfg_rvalid_i),
    .sauria_done_i (sauria_done_i),
    .busy_o        (busy_o),
    .irq_o         (irq_o),
    .err_o         (err_o),
    .jobs_done_o   (jobs_done_o)
  );

  always #5 clk_i = ~clk_i;
  always @(posedge clk_i) cyc <= cyc + 1;

  // Reg-bus slave and SAURIA model; also watches bus protocol and irq pulses.
  always @(negedge clk_i) begin
    cfg_gnt_i    = 1'b0;
    cfg_rvalid_i = 1'b0;
    if (!rst_ni) begin
      gnt_cnt       = 0;
      rsp_cnt       = 0;
      done_timer    = 0;
      sauria_done_i = 1'b0;
      prev_wait     = 1'b0;
      prev_irq      = 1'b0;
    end else begin
      if (irq_o) begin
        if (prev_irq) proto_err++;
        irq_cnt++;
        last_irq_cyc = cyc;
      end
      prev_irq = irq_o;
      if (done_timer > 0) begin
        done_timer--;
        if (done_timer == 0) sauria_done_i = 1'b1;
      end
      if (cfg_req_o && (!cfg_we_o || rsp_cnt > 0)) proto_err++;
      if (cfg_req_o && prev_wait && (cfg_addr_o != prev_addr || cfg_wdata_o != prev_wdata)) proto_err++;
      prev_wait = 1'b0;
      if (rsp_cnt > 0) begin
        rsp_cnt--;
        if (rsp_cnt == 0) begin
          cfg_rvalid_i = 1'b1;
          if (pend_addr == START_A) start_rv_cyc = cyc;
        end
      end else if (cfg_req_o) begin
        if (gnt_cnt <= 0) begin
          cfg_gnt_i = 1'b1;
          log_mem[log_n] = {cfg_addr_o, cfg_wdata_o};
          log_n++;
          pend_addr = cfg_addr_o;
          rsp_cnt = int'($urandom_range(rsp_hi, rsp_lo));
          gnt_cnt = int'($urandom_range(gnt_hi, 0));
          if (cfg_addr_o == START_A) begin
            sauria_done_i = 1'b0;
            if (done_en) done_timer = 3;
          end
          if (cfg_addr_o == CLR_A) sauria_done_i = 1'b0;
        end else begin
          gnt_cnt--;
          prev_wait  = 1'b1;
          prev_addr  = cfg_addr_o;
          prev_wdata = cfg_wdata_o;
        end
      end
    end
  end

  task automatic step();
    @(negedge clk_i);
    #1;
  endtask

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, required %0h", name, act, exp);
  endtask

  function automatic sauria_job_t make_job(input int id);
    sauria_job_t d;
    for (int k = 0; k < 8; k++) d[k] = {8'(id), 8'(k), 16'(32'h9E37 * (id * 8 + k + 1))};
    return d;
  endfunction

  task automatic add_exp(input sauria_job_t d, input int nw, input bit st, input bit cl);
    for (int k = 0; k < nw; k++) begin
      exp_mem[exp_n] = {32'(4 * k), d[k]};
      exp_n++;
    end
    if (st) begin exp_mem[exp_n] = {START_A, 32'h1}; exp_n++; end
    if (cl) begin exp_mem[exp_n] = {CLR_A, 32'h1}; exp_n++; end
  endtask

  task automatic push_job(input sauria_job_t d);
    int n = 0;
    job_data_i  = d;
    job_valid_i = 1'b1;
    while (!job_ready_o && n < 5000) begin step(); n++; end
    if (!job_ready_o) begin
      n_chk++;
      $display("FAIL push: job_ready_o low for %0d cycles, required 1", n);
    end
    step();
    job_valid_i = 1'b0;
  endtask

  task automatic wait_idle(input string name);
    int n = 0;
    int quiet = 0;
    while (quiet < 4 && n < 20000) begin
      step();
      n++;
      if (busy_o) quiet = 0;
      else quiet++;
    end
    if (quiet < 4) begin
      n_chk++;
      $display("FAIL %s idle: busy_o still 1 after %0d cycles, required 0", name, n);
    end
  endtask

  task automatic wait_irq(input string name, input int base);
    int n = 0;
    while (irq_cnt <= base && n < 2000) begin step(); n++; end
    if (irq_cnt <= base) begin
      n_chk++;
      $display("FAIL %s irq: no irq_o within %0d cycles, required a pulse", name, n);
    end
  endtask

  task automatic check_log(input string name);
    int bad = 0;
    check({name, " write count"}, 64'(log_n - lb), 64'(exp_n - eb));
    for (int i = 0; i < exp_n - eb && i < log_n - lb; i++) begin
      if (log_mem[lb + i] !== exp_mem[eb + i]) begin
        if (bad == 0) $display("  %s first bad write %0d: got %h, required %h", name, i, log_mem[lb + i], exp_mem[eb + i]);
        bad++;
      end
    end
    check({name, " write contents"}, 64'(bad), 64'(0));
    lb = log_n;
    eb = exp_n;
  endtask

  initial begin
    #500000;
    $display("FAIL global time limit reached");
    $fatal(1, "time limit");
  end

  initial begin
    vec_t vt[3];
    sauria_job_t d;
    int irq0;
    int n;
    string nm;

    vt[0] = '{gnt_hi: 0, rsp_lo: 1, rsp_hi: 1, njobs: 1, exp_irq: 1, exp_done: 1};
    vt[1] = '{gnt_hi: 7, rsp_lo: 1, rsp_hi: 8, njobs: 3, exp_irq: 3, exp_done: 4};
    vt[2] = '{gnt_hi: 3, rsp_lo: 1, rsp_hi: 2, njobs: 2, exp_irq: 2, exp_done: 6};

    repeat (3) step();
    check("reset job_ready_o", 64'(job_ready_o), 64'(1));
    check("reset busy_o", 64'(busy_o), 64'(0));
    check("reset irq_o", 64'(irq_o), 64'(0));
    check("reset err_o", 64'(err_o), 64'(0));
    check("reset jobs_done_o", 64'(jobs_done_o), 64'(0));
    check("reset cfg_req_o", 64'(cfg_req_o), 64'(0));
    rst_ni = 1'b1;
    step();

    for (int r = 0; r < 3; r++) begin
      nm = $sformatf("row%0d", r);
      gnt_hi = vt[r].gnt_hi;
      rsp_lo = vt[r].rsp_lo;
      rsp_hi = vt[r].rsp_hi;
      irq0 = irq_cnt;
      for (int j = 0; j < vt[r].njobs; j++) begin
        d = make_job(r * 16 + j + 1);
        add_exp(d, 8, 1'b1, 1'b1);
        push_job(d);
      end
      wait_idle(nm);
      check_log(nm);
      check({nm, " irq count"}, 64'(irq_cnt - irq0), 64'(vt[r].exp_irq));
      check({nm, " jobs_done_o"}, 64'(jobs_done_o), 64'(vt[r].exp_done));
      check({nm, " protocol errors"}, 64'(proto_err), 64'(0));
    end

    // Queue backpressure: one running job plus four queued fills the queue.
    gnt_hi = 0; rsp_lo = 1; rsp_hi = 1;
    irq0 = irq_cnt;
    for (int j = 0; j < 5; j++) begin
      d = make_job(64 + j);
      add_exp(d, 8, 1'b1, 1'b1);
      push_job(d);
    end
    check("queue full job_ready_o", 64'(job_ready_o), 64'(0));
    d = make_job(69);
    add_exp(d, 8, 1'b1, 1'b1);
    push_job(d);
    wait_idle("queue");
    check_log("queue order");
    check("queue irq count", 64'(irq_cnt - irq0), 64'(6));
    check("queue jobs_done_o", 64'(jobs_done_o), 64'(12));

    // Watchdog: first job never sees done, second job completes.
    done_en = 1'b0;
    irq0 = irq_cnt;
    d = make_job(80);
    add_exp(d, 8, 1'b1, 1'b0);
    push_job(d);
    d = make_job(81);
    add_exp(d, 8, 1'b1, 1'b1);
    push_job(d);
    wait_irq("timeout", irq0);
    done_en = 1'b1;
    check("timeout err_o", 64'(err_o), 64'(1));
    check("timeout irq latency", 64'(last_irq_cyc - start_rv_cyc), 64'(101));
    check("timeout jobs_done_o", 64'(jobs_done_o), 64'(12));
    wait_idle("timeout");
    check_log("timeout");
    check("timeout irq count", 64'(irq_cnt - irq0), 64'(2));
    check("after timeout jobs_done_o", 64'(jobs_done_o), 64'(13));
    check("err_o sticky", 64'(err_o), 64'(1));
    err_clr_i = 1'b1;
    step();
    err_clr_i = 1'b0;
    check("err_clr err_o", 64'(err_o), 64'(0));

    // Abort while word 3 is granted and its response is outstanding.
    rsp_lo = 6; rsp_hi = 6;
    irq0 = irq_cnt;
    d = make_job(96);
    add_exp(d, 4, 1'b0, 1'b0);
    push_job(d);
    push_job(make_job(97));
    push_job(make_job(98));
    n = 0;
    while (log_n - lb < 4 && n < 500) begin step(); n++; end
    abort_i = 1'b1;
    step();
    abort_i = 1'b0;
    check("abort rvalid still pending busy_o", 64'(busy_o), 64'(1));
    wait_idle("abort");
    check_log("abort");
    check("abort irq count", 64'(irq_cnt - irq0), 64'(0));
    check("abort jobs_done_o", 64'(jobs_done_o), 64'(13));
    check("abort protocol errors", 64'(proto_err), 64'(0));

    // Counter wrap from 16'hFFFF through 0.
    rsp_lo = 1; rsp_hi = 1;
    force dut.jobs_done_q = 16'hFFFF;
    step();
    release dut.jobs_done_q;
    for (int j = 0; j < 2; j++) begin
      d = make_job(100 + j);
      add_exp(d, 8, 1'b1, 1'b1);
      push_job(d);
    end
    wait_idle("wrap");
    check_log("wrap");
    check("wrap jobs_done_o", 64'(jobs_done_o), 64'(1));

    // Asynchronous reset in the middle of configuration.
    push_job(make_job(110));
    n = 0;
    while (log_n - lb < 2 && n < 500) begin step(); n++; end
    #2 rst_ni = 1'b0;
    #1;
    check("mid reset cfg_req_o", 64'(cfg_req_o), 64'(0));
    check("mid reset cfg_addr_o", 64'(cfg_addr_o), 64'(0));
    check("mid reset cfg_wdata_o", 64'(cfg_wdata_o), 64'(0));
    check("mid reset busy_o", 64'(busy_o), 64'(0));
    check("mid reset jobs_done_o", 64'(jobs_done_o), 64'(0));
    check("mid reset job_ready_o", 64'(job_ready_o), 64'(1));
    step();
    step();
    rst_ni = 1'b1;
    repeat (4) step();
    check("after reset stays idle", 64'(busy_o), 64'(0));
    check("final protocol errors", 64'(proto_err), 64'(0));

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
